// File: rtl/mem_stage.sv
// Memory-access stage: registers one instruction from execute, merges SRAM load data, offers it to writeback.
// Latency 1 cycle; holds under !ws_allowin and keeps a copy of load data so later SRAM reads cannot corrupt it.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_allowin,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [70:0] es_to_ms_bus,
    input  logic [31:0] data_sram_rdata,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    output logic [37:0] ms_fwd_bus,
    output logic        out_ms_valid
);

    typedef struct packed {
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_bus_t;

    logic        ms_valid_q, ms_valid_d;
    es_bus_t     bus_q, bus_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;
    logic        rdata_held_q, rdata_held_d;

    logic        ms_ready_go;
    logic [31:0] mem_rdata;
    logic [31:0] final_result;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign out_ms_valid   = ms_valid_q;

    // SRAM data is only ours in the first valid cycle; afterwards use the captured copy.
    assign mem_rdata    = rdata_held_q ? rdata_buf_q : data_sram_rdata;
    assign final_result = bus_q.res_from_mem ? mem_rdata : bus_q.alu_result;

    assign ms_to_ws_bus = {bus_q.gr_we, bus_q.dest, final_result, bus_q.pc};
    assign ms_fwd_bus   = {ms_valid_q && bus_q.gr_we, bus_q.dest, final_result};

    always_comb begin
        ms_valid_d   = ms_valid_q;
        bus_d        = bus_q;
        rdata_buf_d  = rdata_buf_q;
        rdata_held_d = rdata_held_q;

        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
        if (es_to_ms_valid && ms_allowin) begin
            bus_d = es_to_ms_bus;
        end

        // Leaving clears the flag so it never carries into the next instruction.
        if (ms_valid_q && ws_allowin) begin
            rdata_held_d = 1'b0;
        end else if (ms_valid_q && !ws_allowin && !rdata_held_q) begin
            rdata_buf_d  = data_sram_rdata;
            rdata_held_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_q   <= 1'b0;
            bus_q        <= '0;
            rdata_buf_q  <= 32'h0;
            rdata_held_q <= 1'b0;
        end else begin
            ms_valid_q   <= ms_valid_d;
            bus_q        <= bus_d;
            rdata_buf_q  <= rdata_buf_d;
            rdata_held_q <= rdata_held_d;
        end
    end

endmodule
